// File: rtl/pe_feeder.sv
// Operand sequencer for one PE: buffers filter/ifmap values, then replays them as WS or OS strobe trains.
// Outputs are registered and lead the accepting edge by one cycle; no backpressure, writes while busy are dropped.
module pe_feeder #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wr_en_i,
  input  logic                    wr_sel_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [$clog2(DEPTH):0]  len_i,
  input  logic                    mode_i,
  input  logic                    go_i,
  input  logic                    psum_valid_i,
  output logic [DATA_W-1:0]       filter_o,
  output logic [DATA_W-1:0]       ifmap_o,
  output logic                    read_new_filter_val_o,
  output logic                    read_new_ifmap_val_o,
  output logic                    start_o,
  output logic                    end_os_o,
  output logic                    mode_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    ovf_o,
  output logic                    timeout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int MX = (TIMEOUT > DEPTH) ? TIMEOUT : DEPTH;
  localparam int CW = $clog2(MX) + 1;

  typedef enum logic [2:0] {IDLE, LOAD_F, START, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              mode_q, mode_d;
  logic [LW-1:0]     wptr_f, wptr_i;
  logic [DATA_W-1:0] fmem [DEPTH];
  logic [DATA_W-1:0] imem [DEPTH];

  logic          go_ok, accept, reject, last_op, tmo_hit;
  logic          wr_full, wr_ok, wr_drop;
  logic          rd_f_d, rd_i_d, end_os_d;
  logic [AW-1:0] ra;

  assign go_ok   = (len_i != '0) && (len_i <= LW'(DEPTH)) &&
                   (wptr_f >= len_i) && (wptr_i >= len_i);
  assign accept  = (state_q == IDLE) && go_i && go_ok;
  assign reject  = (state_q == IDLE) && go_i && !go_ok;
  assign wr_full = wr_sel_i ? (wptr_i == LW'(DEPTH)) : (wptr_f == LW'(DEPTH));
  assign wr_ok   = (state_q == IDLE) && wr_en_i && !wr_full;
  assign wr_drop = (state_q == IDLE) && wr_en_i && wr_full;
  assign last_op = (idx_q == CW'(len_q) - CW'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = mode_i ? START : LOAD_F;
          idx_d   = '0;
          len_d   = len_i;
          mode_d  = mode_i;
        end
      end
      LOAD_F: begin
        if (last_op) begin
          state_d = START;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      START: begin
        state_d = STREAM;
        idx_d   = '0;
      end
      STREAM: begin
        if (last_op) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      DRAIN: begin
        if (psum_valid_i) begin
          state_d = DONE;
        end else if (idx_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          tmo_hit = 1'b1;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next-state view so the PE sees cycle k's values during cycle k.
  assign rd_f_d   = (state_d == LOAD_F) || ((state_d == STREAM) && mode_d);
  assign rd_i_d   = (state_d == STREAM);
  assign end_os_d = (state_d == STREAM) && mode_d && (idx_d == CW'(len_d) - CW'(1));
  assign ra       = idx_d[AW-1:0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q               <= IDLE;
      idx_q                 <= '0;
      len_q                 <= '0;
      mode_q                <= 1'b0;
      wptr_f                <= '0;
      wptr_i                <= '0;
      filter_o              <= '0;
      ifmap_o               <= '0;
      read_new_filter_val_o <= 1'b0;
      read_new_ifmap_val_o  <= 1'b0;
      start_o               <= 1'b0;
      end_os_o              <= 1'b0;
      mode_o                <= 1'b0;
      busy_o                <= 1'b0;
      done_o                <= 1'b0;
      err_o                 <= 1'b0;
      ovf_o                 <= 1'b0;
      timeout_o             <= 1'b0;
    end else begin
      state_q               <= state_d;
      idx_q                 <= idx_d;
      len_q                 <= len_d;
      mode_q                <= mode_d;
      read_new_filter_val_o <= rd_f_d;
      read_new_ifmap_val_o  <= rd_i_d;
      start_o               <= (state_d == START);
      end_os_o              <= end_os_d;
      mode_o                <= mode_d;
      busy_o                <= (state_d != IDLE);
      done_o                <= (state_d == DONE);
      if (rd_f_d) filter_o <= fmem[ra];
      if (rd_i_d) ifmap_o  <= imem[ra];

      if (state_q == DONE) begin
        wptr_f <= '0;
        wptr_i <= '0;
      end else if (wr_ok) begin
        if (wr_sel_i) wptr_i <= wptr_i + LW'(1);
        else          wptr_f <= wptr_f + LW'(1);
      end

      if (accept)      err_o <= 1'b0;
      else if (reject) err_o <= 1'b1;

      if (wr_drop)     ovf_o <= 1'b1;
      else if (accept) ovf_o <= 1'b0;

      if (tmo_hit)     timeout_o <= 1'b1;
      else if (accept) timeout_o <= 1'b0;
    end
  end

  // Buffer contents survive runs and reset; only the write pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      if (wr_sel_i) imem[wptr_i[AW-1:0]] <= wr_data_i;
      else          fmem[wptr_f[AW-1:0]] <= wr_data_i;
    end
  end

endmodule
